mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the ALU stage and upstream of register-file writeback. Passes ALU results through in one cycle, executes RV32I loads and stores against a data memory with a req/ready handshake, and holds the pipeline with `stall` while an access is outstanding. Formats load data with byte-lane selection and sign or zero extension.

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: mem_operation encodings,
// boolean and register-number names, and small operation classifiers.
package mem_stage_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lsb);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return lsb[0];
            MEM_LW, MEM_SW:          return lsb != 2'b00;
            default:                 return FALSE;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: selects the byte/half lane addressed by the
// low address bits and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_offset,
    input  logic [3:0]  mem_operation,
    output logic [31:0] result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane selection from the word returned by memory
    always_comb begin
        lane_byte = 8'h00;
        case (byte_offset)
            2'd0: lane_byte = rdata[7:0];
            2'd1: lane_byte = rdata[15:8];
            2'd2: lane_byte = rdata[23:16];
            2'd3: lane_byte = rdata[31:24];
            default: lane_byte = 8'h00;
        endcase
        lane_half = byte_offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension according to the load type
    always_comb begin
        result = 32'h0;
        case (mem_operation)
            MEM_LB:  result = {{24{lane_byte[7]}}, lane_byte};
            MEM_LBU: result = {24'h0, lane_byte};
            MEM_LH:  result = {{16{lane_half[15]}}, lane_half};
            MEM_LHU: result = {16'h0, lane_half};
            MEM_LW:  result = rdata;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through, performs
// loads/stores over a req/ready data-memory port and stalls upstream
// while an access is outstanding.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned-access trap).
//
// state | meaning
// IDLE  | accepting instructions; non-memory ops complete in one edge
// WAIT  | memory request outstanding, waiting for dmem_ready
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [3:0]  mem_operation,
    input  logic        in_dest_register_enable,
    input  logic [4:0]  in_dest_register_number,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic        out_dest_register_enable,
    output logic [4:0]  out_dest_register_number,
    output logic        out_trap,
    output logic [31:0] out_trap_address
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]  state;
    logic [3:0]  op_q;
    logic [1:0]  offset_q;
    logic        dest_en_q;
    logic [4:0]  dest_num_q;
    logic [31:0] load_result;
    logic [31:0] wdata_next;
    logic [3:0]  be_next;
    logic        misalign;
    logic        start_access;
    logic        dest_en_in;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = misaligned(mem_operation, alu_result[1:0]);
`else
    assign misalign = FALSE;
`endif

    assign dest_en_in   = in_dest_register_enable && (in_dest_register_number != REG_X0);
    assign start_access = (state == ST_IDLE) && in_valid && is_mem(mem_operation) && !misalign;
    assign stall        = start_access || ((state == ST_WAIT) && !dmem_ready);

    // Store lane replication and byte enables
    always_comb begin
        wdata_next = store_data;
        be_next    = 4'b0000;
        case (mem_operation)
            MEM_SB: begin
                wdata_next = {4{store_data[7:0]}};
                be_next    = 4'b0001 << alu_result[1:0];
            end
            MEM_SH: begin
                wdata_next = {2{store_data[15:0]}};
                be_next    = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            MEM_SW: be_next = 4'b1111;
            default: be_next = 4'b1111;
        endcase
    end

    mem_load_align u_load_align (
        .rdata         (dmem_rdata),
        .byte_offset   (offset_q),
        .mem_operation (op_q),
        .result        (load_result)
    );

    // Stage FSM, memory request registers and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                    <= ST_IDLE;
            op_q                     <= MEM_NONE;
            offset_q                 <= 2'b00;
            dest_en_q                <= FALSE;
            dest_num_q               <= REG_X0;
            dmem_req                 <= FALSE;
            dmem_we                  <= FALSE;
            dmem_addr                <= 32'h0;
            dmem_wdata               <= 32'h0;
            dmem_be                  <= 4'b0000;
            out_valid                <= FALSE;
            out_result               <= 32'h0;
            out_dest_register_enable <= FALSE;
            out_dest_register_number <= REG_X0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_access) begin
                        state                    <= ST_WAIT;
                        op_q                     <= mem_operation;
                        offset_q                 <= alu_result[1:0];
                        dest_en_q                <= dest_en_in;
                        dest_num_q               <= in_dest_register_number;
                        dmem_req                 <= TRUE;
                        dmem_we                  <= is_store(mem_operation);
                        dmem_addr                <= {alu_result[31:2], 2'b00};
                        dmem_wdata               <= wdata_next;
                        dmem_be                  <= be_next;
                        out_valid                <= FALSE;
                        out_dest_register_enable <= FALSE;
                    end else if (in_valid) begin
                        out_valid                <= TRUE;
                        out_result               <= alu_result;
                        out_dest_register_enable <= dest_en_in && !misalign;
                        out_dest_register_number <= in_dest_register_number;
                    end else begin
                        out_valid                <= FALSE;
                        out_dest_register_enable <= FALSE;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ready) begin
                        state                    <= ST_IDLE;
                        dmem_req                 <= FALSE;
                        dmem_we                  <= FALSE;
                        out_valid                <= TRUE;
                        out_result               <= is_load(op_q) ? load_result : 32'h0;
                        out_dest_register_enable <= is_load(op_q) && dest_en_q;
                        out_dest_register_number <= dest_num_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned-access report, valid alongside the one-cycle bubble-free result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_trap         <= FALSE;
            out_trap_address <= 32'h0;
        end else if ((state == ST_IDLE) && in_valid && misalign) begin
            out_trap         <= TRUE;
            out_trap_address <= alu_result;
        end else begin
            out_trap         <= FALSE;
            out_trap_address <= 32'h0;
        end
    end
`else
    assign out_trap         = FALSE;
    assign out_trap_address = 32'h0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [3:0]  mem_operation = 4'd0;
    logic        in_dest_register_enable = 1'b0;
    logic [4:0]  in_dest_register_number = 5'd0;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_dest_register_enable;
    logic [4:0]  out_dest_register_number;
    logic        out_trap;
    logic [31:0] out_trap_address;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .mem_operation(mem_operation),
        .in_dest_register_enable(in_dest_register_enable),
        .in_dest_register_number(in_dest_register_number),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .out_valid(out_valid), .out_result(out_result),
        .out_dest_register_enable(out_dest_register_enable),
        .out_dest_register_number(out_dest_register_number),
        .out_trap(out_trap), .out_trap_address(out_trap_address)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_result !== 32'h0) $display("FAIL reset_out_result got %h want 0", out_result); else pass_cnt++;
        total_cnt++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) $display("FAIL reset_req_we got %0b%0b want 00", dmem_req, dmem_we); else pass_cnt++;
        total_cnt++; if (dmem_be !== 4'b0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) $display("FAIL reset_dmem got be=%b addr=%h wdata=%h want zeros", dmem_be, dmem_addr, dmem_wdata); else pass_cnt++;
        total_cnt++; if (out_dest_register_enable !== 1'b0 || out_dest_register_number !== 5'd0) $display("FAIL reset_dest got %0b/%0d want 0/0", out_dest_register_enable, out_dest_register_number); else pass_cnt++;
        total_cnt++; if (out_trap !== 1'b0 || out_trap_address !== 32'h0) $display("FAIL reset_trap got %0b/%h want 0/0", out_trap, out_trap_address); else pass_cnt++;
        reset = 1'b0;
        next_cycle();
        total_cnt++; if (out_valid !== 1'b0 || stall !== 1'b0) $display("FAIL idle_after_reset got valid=%0b stall=%0b want 0/0", out_valid, stall); else pass_cnt++;
    endtask

    // Present one non-memory op and check it one edge later.
    task automatic run_none(input logic [31:0] res, input logic [4:0] rd, input logic en,
                            input logic exp_en, input string name);
        in_valid = 1'b1; mem_operation = MEM_NONE; alu_result = res;
        in_dest_register_number = rd; in_dest_register_enable = en;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL %s_stall got %0b want 0", name, stall); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== res || out_dest_register_enable !== exp_en || out_dest_register_number !== rd)
            $display("FAIL %s_out got v=%0b r=%h en=%0b rd=%0d want v=1 r=%h en=%0b rd=%0d",
                     name, out_valid, out_result, out_dest_register_enable, out_dest_register_number, res, exp_en, rd);
        else pass_cnt++;
    endtask

    task automatic test_passthrough();
        run_none(32'h0000_1234, 5'd5, 1'b1, 1'b1, "none_basic");
        in_valid = 1'b0;
        next_cycle();
        total_cnt++; if (out_valid !== 1'b0 || out_dest_register_enable !== 1'b0) $display("FAIL idle_bubble got v=%0b en=%0b want 0/0", out_valid, out_dest_register_enable); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run_none(32'hDEAD_0001, 5'd7, 1'b1, 1'b1, "b2b_0");
        run_none(32'hDEAD_0002, 5'd0, 1'b1, 1'b0, "b2b_x0");
        run_none(32'hDEAD_0003, 5'd31, 1'b0, 1'b0, "b2b_noen");
        in_valid = 1'b0;
        next_cycle();
    endtask

    // Drive one memory op with 'waits' not-ready WAIT cycles and check the
    // request, the stall count and the final result.
    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int waits, input logic [4:0] rd,
                           input logic [31:0] exp_addr, input logic exp_we, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                           input logic exp_en, input string name);
        int stall_cnt;
        stall_cnt = 0;
        in_valid = 1'b1; mem_operation = op; alu_result = addr; store_data = sdata;
        in_dest_register_number = rd; in_dest_register_enable = 1'b1;
        dmem_ready = 1'b0;
        #1;
        if (stall === 1'b1) stall_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_we !== exp_we || out_valid !== 1'b0)
            $display("FAIL %s_req got req=%0b addr=%h we=%0b v=%0b want 1 %h %0b 0", name, dmem_req, dmem_addr, dmem_we, out_valid, exp_addr, exp_we);
        else pass_cnt++;
        if (exp_we) begin
            total_cnt++;
            if (dmem_be !== exp_be || dmem_wdata !== exp_wdata)
                $display("FAIL %s_wr got be=%b wdata=%h want be=%b wdata=%h", name, dmem_be, dmem_wdata, exp_be, exp_wdata);
            else pass_cnt++;
        end
        for (int i = 0; i < waits; i++) begin
            dmem_rdata = 32'h5555_5555;
            #1;
            if (stall === 1'b1) stall_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || out_valid !== 1'b0)
                $display("FAIL %s_hold got req=%0b addr=%h v=%0b want 1 %h 0", name, dmem_req, dmem_addr, out_valid, exp_addr);
            else pass_cnt++;
        end
        dmem_ready = 1'b1; dmem_rdata = rdata;
        #1;
        if (stall === 1'b1) stall_cnt++;
        @(posedge clk); #1;
        dmem_ready = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (stall_cnt != waits + 1) $display("FAIL %s_stall_cycles got %0d want %0d", name, stall_cnt, waits + 1); else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== exp_res || out_dest_register_enable !== exp_en || dmem_req !== 1'b0)
            $display("FAIL %s_result got v=%0b r=%h en=%0b req=%0b want 1 %h %0b 0", name, out_valid, out_result, out_dest_register_enable, dmem_req, exp_res, exp_en);
        else pass_cnt++;
        next_cycle();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL %s_after got v=%0b want 0", name, out_valid); else pass_cnt++;
    endtask

    task automatic test_loads();
        run_mem(MEM_LB,  32'h103, 0, 32'h80FF_0000, 3, 5'd3, 32'h100, 1'b0, 4'b0, 0, 32'hFFFF_FF80, 1'b1, "lb");
        run_mem(MEM_LBU, 32'h103, 0, 32'h80FF_0000, 3, 5'd3, 32'h100, 1'b0, 4'b0, 0, 32'h0000_0080, 1'b1, "lbu");
        run_mem(MEM_LH,  32'h102, 0, 32'h80FF_0000, 0, 5'd4, 32'h100, 1'b0, 4'b0, 0, 32'hFFFF_80FF, 1'b1, "lh");
        run_mem(MEM_LHU, 32'h102, 0, 32'h80FF_0000, 1, 5'd4, 32'h100, 1'b0, 4'b0, 0, 32'h0000_80FF, 1'b1, "lhu");
        run_mem(MEM_LB,  32'h101, 0, 32'h1234_7F00, 0, 5'd6, 32'h100, 1'b0, 4'b0, 0, 32'h0000_007F, 1'b1, "lb_pos");
        run_mem(MEM_LW,  32'h400, 0, 32'h1234_5678, 0, 5'd0, 32'h400, 1'b0, 4'b0, 0, 32'h1234_5678, 1'b0, "lw_x0");
    endtask

    task automatic test_stores();
        run_mem(MEM_SH, 32'h202, 32'h0000_ABCD, 32'hFFFF_FFFF, 0, 5'd9, 32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, "sh");
        run_mem(MEM_SB, 32'h101, 32'h0000_005A, 32'hFFFF_FFFF, 2, 5'd9, 32'h100, 1'b1, 4'b0010, 32'h5A5A_5A5A, 32'h0, 1'b0, "sb");
        run_mem(MEM_SW, 32'h208, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0, 5'd9, 32'h208, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, "sw");
    endtask

    task automatic test_reset_in_wait();
        in_valid = 1'b1; mem_operation = MEM_LW; alu_result = 32'h500;
        in_dest_register_number = 5'd8; in_dest_register_enable = 1'b1;
        next_cycle();
        total_cnt++; if (dmem_req !== 1'b1) $display("FAIL rstwait_enter got req=%0b want 1", dmem_req); else pass_cnt++;
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (dmem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rstwait_async got req=%0b stall=%0b want 0/0", dmem_req, stall); else pass_cnt++;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        dmem_ready = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        next_cycle();
        dmem_ready = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || dmem_req !== 1'b0) $display("FAIL rstwait_late_ready got v=%0b req=%0b want 0/0", out_valid, dmem_req); else pass_cnt++;
        next_cycle();
        total_cnt++; if (out_valid !== 1'b0 || out_result !== 32'h0) $display("FAIL rstwait_after got v=%0b r=%h want 0/0", out_valid, out_result); else pass_cnt++;
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        in_valid = 1'b1; mem_operation = MEM_LW; alu_result = 32'h301;
        in_dest_register_number = 5'd10; in_dest_register_enable = 1'b1;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL trap_stall got %0b want 0", stall); else pass_cnt++;
        next_cycle();
        in_valid = 1'b0;
        total_cnt++;
        if (dmem_req !== 1'b0 || out_valid !== 1'b1 || out_trap !== 1'b1 || out_trap_address !== 32'h301 || out_dest_register_enable !== 1'b0)
            $display("FAIL trap_out got req=%0b v=%0b trap=%0b ta=%h en=%0b want 0 1 1 00000301 0", dmem_req, out_valid, out_trap, out_trap_address, out_dest_register_enable);
        else pass_cnt++;
        next_cycle();
        total_cnt++; if (out_trap !== 1'b0) $display("FAIL trap_clear got %0b want 0", out_trap); else pass_cnt++;
`else
        run_mem(MEM_LW, 32'h301, 0, 32'hCAFE_BABE, 0, 5'd10, 32'h300, 1'b0, 4'b0, 0, 32'hCAFE_BABE, 1'b1, "lw_unaligned");
        total_cnt++; if (out_trap !== 1'b0 || out_trap_address !== 32'h0) $display("FAIL notrap got %0b/%h want 0/0", out_trap, out_trap_address); else pass_cnt++;
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_loads();
        test_stores();
        test_reset_in_wait();
        test_misalign();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
